// File: rtl/memory_io_responder.sv
// memory_io_responder: responder end of the byte-wide memory bus.
// Synchronous byte RAM at addr[17]==0, memory-mapped IO window at addr[17:16]==2'b11
// (offset 0x0 = data port, offset 0x4 = halt). IO writes feed a transmit FIFO drained
// by the UART side. Optional macro IO_RX_EN adds a 1-entry receive register for IO reads.
module memory_io_responder #(
   parameter int unsigned RAM_ADDR_WIDTH = 17,
   parameter int unsigned TX_FIFO_LOG    = 3,
   parameter int unsigned FULL_MARGIN    = 2
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] mem_addr_i,
   input  logic [7:0]  mem_wdata_i,
   input  logic        mem_rw_i,
   output logic [7:0]  mem_rdata_o,
   output logic        io_buffer_full_o,
   output logic [7:0]  tx_data_o,
   output logic        tx_valid_o,
   input  logic        tx_ready_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        halt_out_o,
   output logic        overflow_out_o
);

   localparam int unsigned Depth = 1 << TX_FIFO_LOG;
   localparam logic [TX_FIFO_LOG:0]   DepthCnt  = (TX_FIFO_LOG+1)'(Depth);
   localparam logic [TX_FIFO_LOG:0]   MarginCnt = (TX_FIFO_LOG+1)'(FULL_MARGIN);
   localparam logic [TX_FIFO_LOG:0]   CntOne    = 1;
   localparam logic [TX_FIFO_LOG-1:0] PtrOne    = 1;

   // Address decode
   logic io_sel, ram_sel, io_data, io_halt;
   logic [RAM_ADDR_WIDTH-1:0] ram_idx;

   assign io_sel  = (mem_addr_i[17:16] == 2'b11);
   assign ram_sel = ~mem_addr_i[17];
   assign io_data = io_sel && (mem_addr_i[15:0] == 16'h0000);
   assign io_halt = io_sel && (mem_addr_i[15:0] == 16'h0004);
   assign ram_idx = mem_addr_i[RAM_ADDR_WIDTH-1:0];

   // Upper address bits take no part in decode
   logic unused_addr;
   assign unused_addr = ^mem_addr_i[31:18];

   // Byte RAM storage (contents survive reset)
   logic [7:0] ram_q [2**RAM_ADDR_WIDTH];

   // RAM write port
   always_ff @(posedge clk_i) begin
      if (mem_rw_i && ram_sel) begin
         ram_q[ram_idx] <= mem_wdata_i;
      end
   end

   // Receive path: byte returned for an IO data-port read
   logic [7:0] io_rd_byte;

`ifdef IO_RX_EN
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_full_q, rx_full_d;
   logic       rx_pop;

   assign rx_pop     = !mem_rw_i && io_data;
   assign io_rd_byte = rx_full_q ? rx_data_q : 8'h00;

   // Rx holding register next state: a new strobe wins over a consuming read
   always_comb begin
      rx_data_d = rx_data_q;
      rx_full_d = rx_full_q;
      if (rx_valid_i) begin
         rx_data_d = rx_data_i;
         rx_full_d = 1'b1;
      end else if (rx_pop) begin
         rx_full_d = 1'b0;
      end
   end

   // Rx holding register state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_data_q <= 8'h00;
         rx_full_q <= 1'b0;
      end else begin
         rx_data_q <= rx_data_d;
         rx_full_q <= rx_full_d;
      end
   end
`else
   logic unused_rx;
   assign unused_rx  = ^{rx_data_i, rx_valid_i};
   assign io_rd_byte = 8'h00;
`endif

   // Transmit FIFO
   logic [7:0]             fifo_q [Depth];
   logic [TX_FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [TX_FIFO_LOG:0]   count_q, count_d;
   logic                   full_now, push_req, push, pop;
   logic                   io_full_q, io_full_d;
   logic                   halt_q, halt_d;
   logic                   overflow_q, overflow_d;
   logic [7:0]             rdata_q, rdata_d;

   assign full_now = (count_q == DepthCnt);
   assign push_req = mem_rw_i && io_data;
   assign push     = push_req && !full_now;
   assign pop      = tx_valid_o && tx_ready_i;

   // FIFO storage write
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= mem_wdata_i;
      end
   end

   // FIFO pointers, count, sticky flags and the early-warning full flag
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
         count_d = count_q + CntOne;
      end else if (pop && !push) begin
         count_d = count_q - CntOne;
      end
      // Margin absorbs the controller's check-to-write gap
      io_full_d  = (DepthCnt - count_d) < MarginCnt;
      overflow_d = overflow_q | (push_req & full_now);
      halt_d     = halt_q | (mem_rw_i & io_halt);
   end

   // Read pipe register: holds its value across write cycles
   always_comb begin
      rdata_d = rdata_q;
      if (!mem_rw_i) begin
         if (ram_sel) begin
            rdata_d = ram_q[ram_idx];
         end else if (io_data) begin
            rdata_d = io_rd_byte;
         end else begin
            rdata_d = 8'h00;
         end
      end
   end

   // Control state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         io_full_q  <= 1'b0;
         overflow_q <= 1'b0;
         halt_q     <= 1'b0;
         rdata_q    <= 8'h00;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         io_full_q  <= io_full_d;
         overflow_q <= overflow_d;
         halt_q     <= halt_d;
         rdata_q    <= rdata_d;
      end
   end

   assign tx_valid_o       = (count_q != '0);
   // Head is gated so the uninitialised storage never shows while empty
   assign tx_data_o        = tx_valid_o ? fifo_q[rd_ptr_q] : 8'h00;
   assign mem_rdata_o      = rdata_q;
   assign io_buffer_full_o = io_full_q;
   assign halt_out_o       = halt_q;
   assign overflow_out_o   = overflow_q;

endmodule

// File: tb/tb_memory_io_responder.sv
// Directed testbench for memory_io_responder with hand-computed expectations.
module tb_memory_io_responder;

   localparam logic [31:0] IdleAddr = 32'h0002_0000;  // unmapped, reads return 0
   localparam logic [31:0] IoData   = 32'h0003_0000;
   localparam logic [31:0] IoHalt   = 32'h0003_0004;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] mem_addr_i = IdleAddr;
   logic [7:0]  mem_wdata_i = 8'h00;
   logic        mem_rw_i = 1'b0;
   logic [7:0]  mem_rdata_o;
   logic        io_buffer_full_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b0;
   logic [7:0]  rx_data_i = 8'h00;
   logic        rx_valid_i = 1'b0;
   logic        halt_out_o;
   logic        overflow_out_o;

   int n_vec = 0;
   int n_err = 0;

   memory_io_responder dut (
      .clk_i            (clk_i),
      .rst_ni           (rst_ni),
      .mem_addr_i       (mem_addr_i),
      .mem_wdata_i      (mem_wdata_i),
      .mem_rw_i         (mem_rw_i),
      .mem_rdata_o      (mem_rdata_o),
      .io_buffer_full_o (io_buffer_full_o),
      .tx_data_o        (tx_data_o),
      .tx_valid_o       (tx_valid_o),
      .tx_ready_i       (tx_ready_i),
      .rx_data_i        (rx_data_i),
      .rx_valid_i       (rx_valid_i),
      .halt_out_o       (halt_out_o),
      .overflow_out_o   (overflow_out_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus cycle; outputs are sampled 1 time unit after the capturing edge
   task automatic bus_cycle(input logic rw, input logic [31:0] addr, input logic [7:0] wd);
      mem_rw_i    = rw;
      mem_addr_i  = addr;
      mem_wdata_i = wd;
      @(posedge clk_i);
      #1;
      mem_rw_i    = 1'b0;
      mem_addr_i  = IdleAddr;
      mem_wdata_i = 8'h00;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus_cycle(1'b0, IdleAddr, 8'h00);
   endtask

   logic [7:0] seq4 [4];
   logic [7:0] fifo3 [4];

   initial begin
      seq4  = '{8'h11, 8'h22, 8'h33, 8'h44};
      fifo3 = '{8'hB2, 8'hB3, 8'h5A, 8'h00};

      // Reset state
      #12;
      check_eq("rst_rdata", mem_rdata_o, 8'h00);
      check_eq("rst_tx_valid", tx_valid_o, 1'b0);
      check_eq("rst_tx_data", tx_data_o, 8'h00);
      check_eq("rst_full", io_buffer_full_o, 1'b0);
      check_eq("rst_halt", halt_out_o, 1'b0);
      check_eq("rst_overflow", overflow_out_o, 1'b0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;

      // Single write then read-after-write
      bus_cycle(1'b1, 32'h0000_0010, 8'hA5);
      bus_cycle(1'b0, 32'h0000_0010, 8'h00);
      check_eq("raw_a5", mem_rdata_o, 8'hA5);

      // Burst write; a write cycle must hold the previous read byte
      for (int i = 0; i < 4; i++) bus_cycle(1'b1, 32'h0000_0100 + i, seq4[i]);
      check_eq("rdata_hold_on_write", mem_rdata_o, 8'hA5);
      for (int i = 0; i < 4; i++) begin
         bus_cycle(1'b0, 32'h0000_0100 + i, 8'h00);
         check_eq($sformatf("seq_rd%0d", i), mem_rdata_o, seq4[i]);
      end

      // Unmapped read returns 0; unmapped write does not alias RAM
      bus_cycle(1'b1, 32'h0002_0010, 8'hFF);
      bus_cycle(1'b0, 32'h0000_0010, 8'h00);
      check_eq("unmapped_wr_ignored", mem_rdata_o, 8'hA5);
      bus_cycle(1'b0, 32'h0002_0010, 8'h00);
      check_eq("unmapped_rd", mem_rdata_o, 8'h00);

      // Fill FIFO with the UART stalled
      tx_ready_i = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         bus_cycle(1'b1, IoData, 8'(i));
         check_eq($sformatf("full_after_push%0d", i), io_buffer_full_o, (i == 7) ? 1'b1 : 1'b0);
      end
      check_eq("head_first", tx_data_o, 8'h01);
      check_eq("valid_filled", tx_valid_o, 1'b1);
      bus_cycle(1'b1, IoData, 8'h08);
      check_eq("push8_no_ovf", overflow_out_o, 1'b0);
      bus_cycle(1'b1, IoData, 8'h09);
      check_eq("push9_ovf", overflow_out_o, 1'b1);

      // Drain: exactly bytes 1..8, the dropped 0x09 never appears
      tx_ready_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check_eq($sformatf("drain_valid%0d", i), tx_valid_o, 1'b1);
         check_eq($sformatf("drain_data%0d", i), tx_data_o, 8'(i));
         idle(1);
      end
      check_eq("drained_empty", tx_valid_o, 1'b0);
      check_eq("drained_not_full", io_buffer_full_o, 1'b0);
      check_eq("ovf_sticky", overflow_out_o, 1'b1);

      // Simultaneous push and pop with 3 entries queued
      tx_ready_i = 1'b0;
      bus_cycle(1'b1, IoData, 8'hB1);
      bus_cycle(1'b1, IoData, 8'hB2);
      bus_cycle(1'b1, IoData, 8'hB3);
      check_eq("pp_head_b1", tx_data_o, 8'hB1);
      tx_ready_i = 1'b1;
      bus_cycle(1'b1, IoData, 8'h5A);
      tx_ready_i = 1'b0;
      idle(1);
      check_eq("pp_head_b2", tx_data_o, 8'hB2);
      tx_ready_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("pp_data%0d", i), tx_data_o, fifo3[i]);
         idle(1);
      end
      check_eq("pp_empty", tx_valid_o, 1'b0);
      tx_ready_i = 1'b0;

      // Halt
      bus_cycle(1'b1, IoHalt, 8'h00);
      check_eq("halt_set", halt_out_o, 1'b1);
      idle(3);
      check_eq("halt_sticky", halt_out_o, 1'b1);
      check_eq("halt_no_fifo_push", tx_valid_o, 1'b0);

      // Receive register
      rx_data_i  = 8'h7E;
      rx_valid_i = 1'b1;
      idle(1);
      rx_valid_i = 1'b0;
      bus_cycle(1'b0, IoData, 8'h00);
`ifdef IO_RX_EN
      check_eq("rx_read", mem_rdata_o, 8'h7E);
`else
      check_eq("rx_read_disabled", mem_rdata_o, 8'h00);
`endif
      bus_cycle(1'b0, IoData, 8'h00);
      check_eq("rx_read_again", mem_rdata_o, 8'h00);
`ifdef IO_RX_EN
      // Strobe coinciding with a consuming read keeps the new byte
      rx_data_i  = 8'h3C;
      rx_valid_i = 1'b1;
      bus_cycle(1'b0, IoData, 8'h00);
      rx_valid_i = 1'b0;
      bus_cycle(1'b0, IoData, 8'h00);
      check_eq("rx_strobe_vs_pop", mem_rdata_o, 8'h3C);
`endif

      // Asynchronous reset mid-burst
      bus_cycle(1'b1, IoData, 8'hC1);
      bus_cycle(1'b1, IoData, 8'hC2);
      bus_cycle(1'b0, 32'h0000_0010, 8'h00);
      check_eq("pre_rst_valid", tx_valid_o, 1'b1);
      check_eq("pre_rst_rdata", mem_rdata_o, 8'hA5);
      #2 rst_ni = 1'b0;
      #1;
      check_eq("async_rst_valid", tx_valid_o, 1'b0);
      check_eq("async_rst_rdata", mem_rdata_o, 8'h00);
      check_eq("async_rst_halt", halt_out_o, 1'b0);
      check_eq("async_rst_ovf", overflow_out_o, 1'b0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      idle(1);
      check_eq("post_rst_empty", tx_valid_o, 1'b0);
      bus_cycle(1'b0, 32'h0000_0010, 8'h00);
      check_eq("ram_survives_rst", mem_rdata_o, 8'hA5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
